// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing one single-port 32-bit block RAM among three requesters.
// Registers the winning request onto the RAM port and tags each read return to its issuer.
module ram_arbiter #(
  parameter int ADDR_BITS  = 14,
  parameter int RD_LATENCY = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req0_valid,
  input  logic                 req0_we,
  input  logic [ADDR_BITS-1:0] req0_addr,
  input  logic [3:0]           req0_byteen,
  input  logic [31:0]          req0_wrdata,
  output logic                 req0_ack,
  output logic                 req0_rvalid,
  input  logic                 req1_valid,
  input  logic                 req1_we,
  input  logic [ADDR_BITS-1:0] req1_addr,
  input  logic [3:0]           req1_byteen,
  input  logic [31:0]          req1_wrdata,
  output logic                 req1_ack,
  output logic                 req1_rvalid,
  input  logic                 req2_valid,
  input  logic                 req2_we,
  input  logic [ADDR_BITS-1:0] req2_addr,
  input  logic [3:0]           req2_byteen,
  input  logic [31:0]          req2_wrdata,
  output logic                 req2_ack,
  output logic                 req2_rvalid,
  output logic [31:0]          rddata,
  output logic [ADDR_BITS-1:0] ram_addr,
  output logic [3:0]           ram_byteen,
  output logic [31:0]          ram_wrdata,
  output logic                 ram_rden,
  output logic                 ram_wren,
  input  logic [31:0]          ram_rddata
);
  localparam int N_REQ = 3;

  logic [N_REQ-1:0]     req_valid;
  logic [N_REQ-1:0]     req_we;
  logic [ADDR_BITS-1:0] req_addr   [N_REQ];
  logic [3:0]           req_byteen [N_REQ];
  logic [31:0]          req_wrdata [N_REQ];

  assign req_valid     = {req2_valid, req1_valid, req0_valid};
  assign req_we        = {req2_we, req1_we, req0_we};
  assign req_addr[0]   = req0_addr;
  assign req_addr[1]   = req1_addr;
  assign req_addr[2]   = req2_addr;
  assign req_byteen[0] = req0_byteen;
  assign req_byteen[1] = req1_byteen;
  assign req_byteen[2] = req2_byteen;
  assign req_wrdata[0] = req0_wrdata;
  assign req_wrdata[1] = req1_wrdata;
  assign req_wrdata[2] = req2_wrdata;

  logic [N_REQ-1:0]     ack_reg;
  logic [N_REQ-1:0]     eligible;
  logic [N_REQ-1:0]     rvalid_vec;
  logic [1:0]           last_reg;
  logic [1:0]           grant_id;
  logic [1:0]           cand;
  logic                 grant_any;
  logic [ADDR_BITS-1:0] ram_addr_reg;
  logic [3:0]           ram_byteen_reg;
  logic [31:0]          ram_wrdata_reg;
  logic                 ram_rden_reg;
  logic                 ram_wren_reg;
  logic [2:0]           pipe_reg [RD_LATENCY];  // {valid, id}

  // A requester whose ack is still high must not be granted a second time.
  assign eligible = req_valid & ~ack_reg;

  always_comb begin
    grant_any = 1'b0;
    grant_id  = last_reg;
    cand      = last_reg;
    for (int k = 0; k < N_REQ; k++) begin
      cand = (cand == 2'd2) ? 2'd0 : cand + 2'd1;
      if (!grant_any && eligible[cand]) begin
        grant_any = 1'b1;
        grant_id  = cand;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ack_reg        <= '0;
      last_reg       <= 2'd2;
      ram_addr_reg   <= '0;
      ram_byteen_reg <= '0;
      ram_wrdata_reg <= '0;
      ram_rden_reg   <= 1'b0;
      ram_wren_reg   <= 1'b0;
    end else begin
      ack_reg      <= '0;
      ram_rden_reg <= 1'b0;
      ram_wren_reg <= 1'b0;
      if (grant_any) begin
        ack_reg[grant_id] <= 1'b1;
        last_reg          <= grant_id;
        ram_addr_reg      <= req_addr[grant_id];
        ram_byteen_reg    <= req_byteen[grant_id];
        ram_wrdata_reg    <= req_wrdata[grant_id];
        ram_wren_reg      <= req_we[grant_id];
        ram_rden_reg      <= !req_we[grant_id];
      end
    end
  end

  // last_reg always names the requester behind the access currently on the RAM port.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < RD_LATENCY; s++) pipe_reg[s] <= '0;
    end else begin
      pipe_reg[0] <= {ram_rden_reg, last_reg};
      for (int s = 1; s < RD_LATENCY; s++) pipe_reg[s] <= pipe_reg[s-1];
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_rvalid
      assign rvalid_vec[gi] = pipe_reg[RD_LATENCY-1][2] &&
                              (pipe_reg[RD_LATENCY-1][1:0] == 2'(gi));
    end
  endgenerate

  assign {req2_ack, req1_ack, req0_ack}          = ack_reg;
  assign {req2_rvalid, req1_rvalid, req0_rvalid} = rvalid_vec;
  assign rddata     = ram_rddata;
  assign ram_addr   = ram_addr_reg;
  assign ram_byteen = ram_byteen_reg;
  assign ram_wrdata = ram_wrdata_reg;
  assign ram_rden   = ram_rden_reg;
  assign ram_wren   = ram_wren_reg;
endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: a RD_LATENCY=2 instance plus a RD_LATENCY=4 instance
// sharing the same requester stimulus, each backed by a simple byte-enabled RAM model.
module tb_ram_arbiter;
  localparam int AB = 14;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [2:0]    req_valid;
  logic [2:0]    req_we;
  logic [AB-1:0] req_addr [3];
  logic [3:0]    req_be   [3];
  logic [31:0]   req_wd   [3];

  logic [2:0]    ack, rvalid, ack4, rvalid4;
  logic [31:0]   rddata, rddata4, ram_wrdata, ram4_wrdata, ram_rddata, ram4_rddata;
  logic [AB-1:0] ram_addr, ram4_addr;
  logic [3:0]    ram_byteen, ram4_byteen;
  logic          ram_rden, ram_wren, ram4_rden, ram4_wren;

  ram_arbiter #(.ADDR_BITS(AB), .RD_LATENCY(2)) u_dut (
    .clk(clk), .rst(rst),
    .req0_valid(req_valid[0]), .req0_we(req_we[0]), .req0_addr(req_addr[0]),
    .req0_byteen(req_be[0]), .req0_wrdata(req_wd[0]), .req0_ack(ack[0]), .req0_rvalid(rvalid[0]),
    .req1_valid(req_valid[1]), .req1_we(req_we[1]), .req1_addr(req_addr[1]),
    .req1_byteen(req_be[1]), .req1_wrdata(req_wd[1]), .req1_ack(ack[1]), .req1_rvalid(rvalid[1]),
    .req2_valid(req_valid[2]), .req2_we(req_we[2]), .req2_addr(req_addr[2]),
    .req2_byteen(req_be[2]), .req2_wrdata(req_wd[2]), .req2_ack(ack[2]), .req2_rvalid(rvalid[2]),
    .rddata(rddata), .ram_addr(ram_addr), .ram_byteen(ram_byteen), .ram_wrdata(ram_wrdata),
    .ram_rden(ram_rden), .ram_wren(ram_wren), .ram_rddata(ram_rddata)
  );

  ram_arbiter #(.ADDR_BITS(AB), .RD_LATENCY(4)) u_dut4 (
    .clk(clk), .rst(rst),
    .req0_valid(req_valid[0]), .req0_we(req_we[0]), .req0_addr(req_addr[0]),
    .req0_byteen(req_be[0]), .req0_wrdata(req_wd[0]), .req0_ack(ack4[0]), .req0_rvalid(rvalid4[0]),
    .req1_valid(req_valid[1]), .req1_we(req_we[1]), .req1_addr(req_addr[1]),
    .req1_byteen(req_be[1]), .req1_wrdata(req_wd[1]), .req1_ack(ack4[1]), .req1_rvalid(rvalid4[1]),
    .req2_valid(req_valid[2]), .req2_we(req_we[2]), .req2_addr(req_addr[2]),
    .req2_byteen(req_be[2]), .req2_wrdata(req_wd[2]), .req2_ack(ack4[2]), .req2_rvalid(rvalid4[2]),
    .rddata(rddata4), .ram_addr(ram4_addr), .ram_byteen(ram4_byteen), .ram_wrdata(ram4_wrdata),
    .ram_rden(ram4_rden), .ram_wren(ram4_wren), .ram_rddata(ram4_rddata)
  );

  // RAM model: writes come from the latency-2 instance (both issue identically),
  // each instance reads through its own latency pipe. Backdoor port preloads words.
  logic [31:0]   mem [0:(1<<AB)-1];
  logic [31:0]   rp2 [2];
  logic [31:0]   rp4 [4];
  logic          bd_we;
  logic [AB-1:0] bd_addr;
  logic [31:0]   bd_data;

  always @(posedge clk) begin
    if (bd_we) mem[bd_addr] <= bd_data;
    else if (ram_wren)
      for (int b = 0; b < 4; b++)
        if (ram_byteen[b]) mem[ram_addr][8*b +: 8] <= ram_wrdata[8*b +: 8];
    rp2[0] <= mem[ram_addr];
    rp2[1] <= rp2[0];
    rp4[0] <= mem[ram4_addr];
    for (int k = 1; k < 4; k++) rp4[k] <= rp4[k-1];
  end
  assign ram_rddata  = rp2[1];
  assign ram4_rddata = rp4[3];

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input int id, input logic we, input logic [AB-1:0] a,
                         input logic [3:0] be, input logic [31:0] wd);
    req_valid[id] = 1'b1;
    req_we[id]    = we;
    req_addr[id]  = a;
    req_be[id]    = be;
    req_wd[id]    = wd;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_rden"}, 32'(ram_rden), 32'd0);
    check({tag, "_wren"}, 32'(ram_wren), 32'd0);
    check({tag, "_addr"}, 32'(ram_addr), 32'd0);
    check({tag, "_byteen"}, 32'(ram_byteen), 32'd0);
    check({tag, "_wrdata"}, ram_wrdata, 32'd0);
    check({tag, "_ack"}, 32'({ack4, ack}), 32'd0);
    check({tag, "_rvalid"}, 32'({rvalid4, rvalid}), 32'd0);
  endtask

  logic [31:0] cont_data [3];
  logic [2:0]  exp_ack, exp_rv;

  initial begin
    req_valid = '0;
    req_we    = '0;
    for (int i = 0; i < 3; i++) begin
      req_addr[i] = '0;
      req_be[i]   = 4'hF;
      req_wd[i]   = '0;
    end
    bd_we = 1'b0; bd_addr = '0; bd_data = '0;
    cont_data[0] = 32'hA0A0A0A0;
    cont_data[1] = 32'hB1B1B1B1;
    cont_data[2] = 32'hC2C2C2C2;

    // Preload while held in reset.
    tick();
    bd_we = 1'b1;
    bd_addr = 14'h005; bd_data = 32'hDEADBEEF; tick();
    bd_addr = 14'h010; bd_data = 32'hFFFFFFFF; tick();
    bd_addr = 14'h020; bd_data = cont_data[0]; tick();
    bd_addr = 14'h021; bd_data = cont_data[1]; tick();
    bd_addr = 14'h022; bd_data = cont_data[2]; tick();
    bd_addr = 14'h030; bd_data = 32'h33333333; tick();
    bd_we = 1'b0;
    check_reset_state("reset");
    $display("reset state checked");
    rst = 1'b0;
    tick();

    // Single read from requester 1.
    present(1, 1'b0, 14'h005, 4'hF, 32'h0);
    tick();
    check("rd1_ack", 32'(ack), 32'b010);
    check("rd1_rden", 32'(ram_rden), 32'd1);
    check("rd1_addr", 32'(ram_addr), 32'h005);
    req_valid[1] = 1'b0;
    tick();
    check("rd1_rv_early", 32'(rvalid), 32'd0);
    tick();
    check("rd1_rvalid", 32'(rvalid), 32'b010);
    check("rd1_data", rddata, 32'hDEADBEEF);
    check("rd1_lat4_early", 32'(rvalid4), 32'd0);
    tick();
    check("rd1_rv_after", 32'(rvalid), 32'd0);
    tick();
    check("rd1_lat4_rvalid", 32'(rvalid4), 32'b010);
    check("rd1_lat4_data", rddata4, 32'hDEADBEEF);
    tick();
    check("rd1_lat4_after", 32'(rvalid4), 32'd0);
    $display("single read req1 addr 005 done");

    // Partial write then read-back from requester 0.
    present(0, 1'b1, 14'h010, 4'b0011, 32'h12345678);
    tick();
    check("wr_ack", 32'(ack), 32'b001);
    check("wr_wren", 32'(ram_wren), 32'd1);
    check("wr_rden", 32'(ram_rden), 32'd0);
    check("wr_byteen", 32'(ram_byteen), 32'b0011);
    check("wr_wrdata", ram_wrdata, 32'h12345678);
    req_valid[0] = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      check("wr_no_rvalid", 32'({rvalid4, rvalid}), 32'd0);
    end
    present(0, 1'b0, 14'h010, 4'hF, 32'h0);
    tick();
    check("rb_ack", 32'(ack), 32'b001);
    req_valid[0] = 1'b0;
    tick();
    tick();
    check("rb_rvalid", 32'(rvalid), 32'b001);
    check("rb_data", rddata, 32'hFFFF5678);
    repeat (3) tick();
    $display("write 010 be 0011 then read-back done");

    // Three-way contention straight after reset.
    rst = 1'b1; tick(); rst = 1'b0;
    present(0, 1'b0, 14'h020, 4'hF, 32'h0);
    present(1, 1'b0, 14'h021, 4'hF, 32'h0);
    present(2, 1'b0, 14'h022, 4'hF, 32'h0);
    for (int c = 1; c <= 5; c++) begin
      tick();
      exp_ack = (c == 1) ? 3'b001 : (c == 2) ? 3'b010 : (c == 3) ? 3'b100 : 3'b000;
      exp_rv  = (c == 3) ? 3'b001 : (c == 4) ? 3'b010 : (c == 5) ? 3'b100 : 3'b000;
      check("cont_ack", 32'(ack), 32'(exp_ack));
      check("cont_rvalid", 32'(rvalid), 32'(exp_rv));
      if (c >= 3) check("cont_data", rddata, cont_data[c-3]);
      req_valid = req_valid & ~ack;
    end
    repeat (3) tick();
    $display("three-way contention done");

    // Fairness between requesters 0 and 2, with last = 0.
    present(0, 1'b0, 14'h030, 4'hF, 32'h0);
    tick();
    check("fair_setup_ack", 32'(ack), 32'b001);
    req_valid[0] = 1'b0;
    tick();
    present(0, 1'b0, 14'h030, 4'hF, 32'h0);
    present(2, 1'b0, 14'h030, 4'hF, 32'h0);
    for (int c = 1; c <= 10; c++) begin
      tick();
      check("fair_ack", 32'(ack), (c % 2 == 1) ? 32'b100 : 32'b001);
    end
    req_valid = '0;
    repeat (6) tick();
    $display("fairness 0/2 alternation done");

    // Reset while a read is in flight.
    present(1, 1'b0, 14'h005, 4'hF, 32'h0);
    tick();
    check("rstf_ack", 32'(ack), 32'b010);
    req_valid[1] = 1'b0;
    rst = 1'b1;
    tick();
    check_reset_state("rstf");
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tick();
      check("rstf_no_rvalid", 32'({rvalid4, rvalid}), 32'd0);
    end
    $display("reset during read flight done");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
